sevenseg_scanner: RTL
=====================

# sevenseg_scanner

Time-multiplexed 4-digit seven-segment display driver that consumes the `BCDnumber_t [3:0] digit` bus produced by `stopwatch` and drives the board's anode/segment pins. It snapshots the digits once per frame so a display frame never mixes old and new values, scans one digit at a time with a guard cycle against ghosting, decodes BCD to segments, and optionally blanks leading zeros. It sits between the stopwatch counter and the top-level pins.

## Interface
- `REFRESH_DIV`, 50000: clock cycles per digit slot; legal range ≥ 2.
- `ACTIVE_LOW`, 1: when 1, `an`, `seg` and `dp` are inverted at the output. The logical "on" level is 1 throughout this document.
- `clk`  in  1: system clock; the single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `digit`  in  `BCDnumber_t [3:0]`: digit[0] is the rightmost (least significant) digit.
- `dp_mask`  in  4: decimal point enable per digit.
- `lzb`  in  1: leading-zero blanking enable.
- `an`  out  4: one-hot digit enable; an[k] selects digit k.
- `seg`  out  7: segments {g,f,e,d,c,b,a}.
- `dp`  out  1: decimal point of the active digit.
- `frame_start`  out  1: one-cycle pulse in the first cycle of each frame.

## Operation
- Slot counter `c` runs 0..REFRESH_DIV-1 and wraps. On wrap, digit index `i` advances 0→1→2→3→0.
- Snapshot registers `snap_digit`, `snap_dp` and `snap_lzb` load `digit`, `dp_mask` and `lzb` in the cycle where c==REFRESH_DIV-1 and i==3 (end of frame). They hold for the entire next frame. Input changes mid-frame are invisible until the next frame.
- Guard cycle: when c==0, `an`=0, `seg`=0 and `dp`=0. When c≠0, `an`=onehot(i), `seg`=decode(snap_digit[i]), and `dp`=snap_dp[i].
- Decode: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F. Values 10..15 are invalid and show a dash (40).
- Leading-zero blanking: when snap_lzb=1, digit k in 3..1 is blanked (`seg`=0) if snap_digit[j]==0 for all j≥k. Digit 0 is never blanked.
  - `an` still asserts for a blanked digit.
  - `dp` is unaffected by blanking.
  - Invalid codes count as non-zero.
- `frame_start`=1 exactly when c==0 and i==0, except in the first cycle after reset (see Timing).

## Timing
- All outputs are driven from flops: a registered image of (c, i, snapshot). They change only on `clk` rising edges.
- Reset (rst=1 at an edge):
  - c=0, i=0, snapshots=0, snap_lzb=0.
  - `an`=0, `seg`=0, `dp`=0, `frame_start`=0. Physical pins are at the inactive level per ACTIVE_LOW.
- Reset mid-scan aborts the frame immediately. No partial snapshot is kept.
- First cycle after reset release: c=0, i=0, guard cycle, `frame_start`=0. The first frame displays the reset snapshot: "0" on digit 0 and zeros on digits 1..3, since snap_lzb=0.
- The first snapshot of live inputs is taken at the end of the first frame.
- Frame length is 4·REFRESH_DIV cycles.
- Each digit is lit for REFRESH_DIV-1 cycles per frame, preceded by one dark guard cycle.
- `frame_start` period is 4·REFRESH_DIV cycles from the second frame onward.
- Simultaneous input change and snapshot edge: the value present at that edge is captured.

## Structure
- Package `packs` (already holds `BCDnumber_t`) gains:
  - `seg7_t` (logic [6:0]).
  - Constants `SEG7_DASH` and `SEG7_BLANK`.
- Sub-module `bcd_to_seg7` is purely combinational (`BCDnumber_t` → `seg7_t`, with the dash on invalid codes). It is instantiated once, on the muxed snapshot digit.
- Polarity inversion happens only at the output flops.

## Test plan
All scenarios use REFRESH_DIV=4, ACTIVE_LOW=0 and a frame of 16 cycles.
- Reset with digit={1,2,3,4} (d3..d0): hold rst for 3 cycles, then release.
  - `an`,`seg`,`dp`=0 during reset.
  - Frame 1 shows 3F on every digit.
  - Frame 2 shows an=0001/seg=66, an=0010/seg=4F, an=0100/seg=5B, an=1000/seg=06.
  - Each digit is preceded by one guard cycle with an=0.
- Mid-frame change: in frame 2, change digit[0] 4→9 at slot 2.
  - Frame 2 still shows 66 on digit 0.
  - Frame 3 shows 6F.
- Leading-zero blanking: digit={0,0,7,0} with lzb=1.
  - an=1000 and an=0100 show seg=00.
  - an=0010 shows 07.
  - an=0001 shows 3F.
  - With digit={0,0,0,0}, only digit 0 shows 3F.
- Invalid BCD and dp: digit[2]=4'hC with dp_mask=0100 → digit 2 shows seg=40 with dp=1; all other digits have dp=0.
- `frame_start` and reset mid-scan:
  - `frame_start` pulses every 16 cycles from frame 2 onward.
  - Assert rst at i=2, c=3 → the next cycle has all outputs 0, and the scan restarts at i=0.
- ACTIVE_LOW=1, digit={8,8,8,8}:
  - During reset, an=1111 and seg=7F.
  - While lit, the active digit has an bit 0 and seg=00.

Source files
------------

// File: rtl/packs.sv
// Shared display types: BCD digit code, seven-segment pattern and its fixed patterns.
package packs;

  typedef logic [3:0] BCDnumber_t;
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_DASH  = 7'h40;
  localparam seg7_t SEG7_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
  import packs::*;
(
  input  BCDnumber_t bcd,
  output seg7_t      seg_c
);

  always_comb begin
    seg_c = SEG7_DASH;
    case (bcd)
      4'd0:    seg_c = 7'h3F;
      4'd1:    seg_c = 7'h06;
      4'd2:    seg_c = 7'h5B;
      4'd3:    seg_c = 7'h4F;
      4'd4:    seg_c = 7'h66;
      4'd5:    seg_c = 7'h6D;
      4'd6:    seg_c = 7'h7D;
      4'd7:    seg_c = 7'h07;
      4'd8:    seg_c = 7'h7F;
      4'd9:    seg_c = 7'h6F;
      default: seg_c = SEG7_DASH;
    endcase
  end

endmodule

// File: rtl/sevenseg_scanner.sv
// Four-digit multiplexed seven-segment driver with per-frame input snapshot,
// one dark guard cycle per digit slot and optional leading-zero blanking.
module sevenseg_scanner
  import packs::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  BCDnumber_t [3:0] digit,
  input  logic [3:0]       dp_mask,
  input  logic             lzb,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             frame_start
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] C_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]    c_q, c_d;
  logic [1:0]       i_q, i_d;
  BCDnumber_t [3:0] snap_digit_q, snap_digit_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic             snap_lzb_q, snap_lzb_d;

  BCDnumber_t       cur_digit;
  seg7_t            dec_seg;
  logic [3:0]       zero_above;
  logic             blank;
  logic [3:0]       an_d;
  seg7_t            seg_d;
  logic             dp_d;
  logic             fs_d;

  // Slot/digit counters and end-of-frame snapshot load.
  always_comb begin
    c_d          = c_q + CW'(1);
    i_d          = i_q;
    snap_digit_d = snap_digit_q;
    snap_dp_d    = snap_dp_q;
    snap_lzb_d   = snap_lzb_q;
    if (c_q == C_LAST) begin
      c_d = '0;
      i_d = i_q + 2'd1;
      if (i_q == 2'd3) begin
        snap_digit_d = digit;
        snap_dp_d    = dp_mask;
        snap_lzb_d   = lzb;
      end
    end
  end

  assign cur_digit = snap_digit_d[i_d];

  bcd_to_seg7 u_dec (
    .bcd   (cur_digit),
    .seg_c (dec_seg)
  );

  // Output image of the next state, so the flops line up with (c, i).
  always_comb begin
    zero_above    = '0;
    zero_above[3] = (snap_digit_d[3] == 4'd0);
    zero_above[2] = zero_above[3] & (snap_digit_d[2] == 4'd0);
    zero_above[1] = zero_above[2] & (snap_digit_d[1] == 4'd0);
    blank = snap_lzb_d & zero_above[i_d];
    an_d  = '0;
    seg_d = SEG7_BLANK;
    dp_d  = 1'b0;
    if (c_d != '0) begin
      an_d  = 4'(1) << i_d;
      seg_d = blank ? SEG7_BLANK : dec_seg;
      dp_d  = snap_dp_d[i_d];
    end
    fs_d = (c_d == '0) && (i_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q          <= '0;
      i_q          <= '0;
      snap_digit_q <= '0;
      snap_dp_q    <= '0;
      snap_lzb_q   <= 1'b0;
      an           <= {4{ACTIVE_LOW}};
      seg          <= {7{ACTIVE_LOW}};
      dp           <= ACTIVE_LOW;
      frame_start  <= 1'b0;
    end else begin
      c_q          <= c_d;
      i_q          <= i_d;
      snap_digit_q <= snap_digit_d;
      snap_dp_q    <= snap_dp_d;
      snap_lzb_q   <= snap_lzb_d;
      an           <= an_d ^ {4{ACTIVE_LOW}};
      seg          <= seg_d ^ {7{ACTIVE_LOW}};
      dp           <= dp_d ^ ACTIVE_LOW;
      frame_start  <= fs_d;
    end
  end

endmodule
